// File: rtl/spram_rw_ctrl.sv
// Single-port RAM access controller: arbitrates independent write and read request
// streams onto one RAM port, tracks read latency and returns read data in order
// through a credit-limited response FIFO.
module spram_rw_ctrl #(
  parameter int unsigned RAM_DO_REG    = 0,
  parameter int unsigned RAM_WIDTH     = 8,
  parameter int unsigned RAM_DEEP      = 10,
  parameter int unsigned RD_FIFO_DEPTH = 4
) (
  input  logic                                   i_clock,
  input  logic                                   i_reset,
  input  logic                                   i_wr_req_vld,
  output logic                                   o_wr_req_rdy,
  input  logic [RAM_DEEP-1:0]                    i_wr_addr,
  input  logic [RAM_WIDTH-1:0]                   i_wr_data,
  input  logic                                   i_rd_req_vld,
  output logic                                   o_rd_req_rdy,
  input  logic [RAM_DEEP-1:0]                    i_rd_addr,
  output logic                                   o_rd_rsp_vld,
  input  logic                                   i_rd_rsp_rdy,
  output logic [RAM_WIDTH-1:0]                   o_rd_rsp_data,
  output logic [$clog2(RD_FIFO_DEPTH+1)-1:0]     o_rd_outstanding,
  output logic                                   o_ram_wren,
  output logic                                   o_ram_ren,
  output logic [RAM_DEEP-1:0]                    o_ram_address,
  output logic [RAM_WIDTH-1:0]                   o_ram_wdata,
  input  logic [RAM_WIDTH-1:0]                   i_ram_q
);

  localparam int unsigned CntW = $clog2(RD_FIFO_DEPTH + 1);
  localparam int unsigned LatD = 1 + RAM_DO_REG;
  localparam int unsigned PtrW = (RD_FIFO_DEPTH > 1) ? $clog2(RD_FIFO_DEPTH) : 1;
  localparam logic [CntW-1:0] Credits = CntW'(RD_FIFO_DEPTH);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(RD_FIFO_DEPTH - 1);

  logic                 r_prio_rd;
  logic [CntW-1:0]      r_outstanding;
  logic                 r_ram_wren;
  logic                 r_ram_ren;
  logic [RAM_DEEP-1:0]  r_ram_address;
  logic [RAM_WIDTH-1:0] r_ram_wdata;
  logic [LatD-1:0]      r_lat;
  logic [RAM_WIDTH-1:0] r_fifo [RD_FIFO_DEPTH];
  logic [PtrW-1:0]      r_wptr;
  logic [PtrW-1:0]      r_rptr;
  logic [CntW-1:0]      r_fcnt;

  logic w_rd_req;
  logic w_wr_req;
  logic w_gnt_rd;
  logic w_gnt_wr;
  logic w_push;
  logic w_pop;
  logic w_nempty;

  // Requests are masked during reset so nothing is accepted then.
  assign w_rd_req = i_rd_req_vld & (r_outstanding < Credits) & ~i_reset;
  assign w_wr_req = i_wr_req_vld & ~i_reset;
  assign w_gnt_rd = w_rd_req & (~w_wr_req | r_prio_rd);
  assign w_gnt_wr = w_wr_req & (~w_rd_req | ~r_prio_rd);
  assign w_push   = r_lat[LatD-1];
  assign w_nempty = (r_fcnt != '0);
  assign w_pop    = w_nempty & i_rd_rsp_rdy;

  assign o_wr_req_rdy     = w_gnt_wr;
  assign o_rd_req_rdy     = w_gnt_rd;
  assign o_rd_rsp_vld     = w_nempty;
  assign o_rd_rsp_data    = w_nempty ? r_fifo[r_rptr] : '0;
  assign o_rd_outstanding = r_outstanding;
  assign o_ram_wren       = r_ram_wren;
  assign o_ram_ren        = r_ram_ren;
  assign o_ram_address    = r_ram_address;
  assign o_ram_wdata      = r_ram_wdata;

  // Priority flag flips only on contended grants, giving R,W,R,W under contention.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_prio_rd <= 1'b1;
    end else if (w_rd_req & w_wr_req) begin
      r_prio_rd <= ~r_prio_rd;
    end
  end

  // Registered command stage towards the RAM; address/wdata hold when idle.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_ram_wren    <= 1'b0;
      r_ram_ren     <= 1'b0;
      r_ram_address <= '0;
      r_ram_wdata   <= '0;
    end else begin
      r_ram_wren <= w_gnt_wr;
      r_ram_ren  <= w_gnt_rd;
      if (w_gnt_wr) begin
        r_ram_address <= i_wr_addr;
        r_ram_wdata   <= i_wr_data;
      end else if (w_gnt_rd) begin
        r_ram_address <= i_rd_addr;
      end
    end
  end

  // Latency pipe: marks the cycle in which ram_q carries data for an issued read.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_lat <= '0;
    end else begin
      r_lat <= (r_lat << 1) | LatD'(r_ram_ren);
    end
  end

  // Read credits: accepted reads not yet popped; a same-cycle accept and pop cancel.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_outstanding <= '0;
    end else begin
      case ({w_gnt_rd, w_pop})
        2'b10:   r_outstanding <= r_outstanding + 1'b1;
        2'b01:   r_outstanding <= r_outstanding - 1'b1;
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  // Response FIFO storage; contents need no reset since pointers and count do.
  always_ff @(posedge i_clock) begin
    if (w_push) begin
      r_fifo[r_wptr] <= i_ram_q;
    end
  end

  // Response FIFO pointers and occupancy; credits guarantee no overflow.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_fcnt <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= (r_wptr == PtrLast) ? '0 : r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= (r_rptr == PtrLast) ? '0 : r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_fcnt <= r_fcnt + 1'b1;
        2'b01:   r_fcnt <= r_fcnt - 1'b1;
        default: r_fcnt <= r_fcnt;
      endcase
    end
  end

endmodule

// File: tb/tb_spram_rw_ctrl.sv
// Bench for spram_rw_ctrl: attached RAM model, shadow-memory scoreboard monitor,
// directed scenarios followed by a randomized phase.
module tb_spram_rw_ctrl;

  localparam int DoReg = 0;
  localparam int W     = 8;
  localparam int AW    = 10;
  localparam int Depth = 4;
  localparam int OW    = $clog2(Depth + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_req_vld = 1'b0;
  logic          wr_req_rdy;
  logic [AW-1:0] wr_addr = '0;
  logic [W-1:0]  wr_data = '0;
  logic          rd_req_vld = 1'b0;
  logic          rd_req_rdy;
  logic [AW-1:0] rd_addr = '0;
  logic          rd_rsp_vld;
  logic          rd_rsp_rdy = 1'b1;
  logic [W-1:0]  rd_rsp_data;
  logic [OW-1:0] rd_outstanding;
  logic          ram_wren;
  logic          ram_ren;
  logic [AW-1:0] ram_address;
  logic [W-1:0]  ram_wdata;
  logic [W-1:0]  ram_q;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  spram_rw_ctrl #(
    .RAM_DO_REG   (DoReg),
    .RAM_WIDTH    (W),
    .RAM_DEEP     (AW),
    .RD_FIFO_DEPTH(Depth)
  ) dut (
    .i_clock         (clk),
    .i_reset         (rst),
    .i_wr_req_vld    (wr_req_vld),
    .o_wr_req_rdy    (wr_req_rdy),
    .i_wr_addr       (wr_addr),
    .i_wr_data       (wr_data),
    .i_rd_req_vld    (rd_req_vld),
    .o_rd_req_rdy    (rd_req_rdy),
    .i_rd_addr       (rd_addr),
    .o_rd_rsp_vld    (rd_rsp_vld),
    .i_rd_rsp_rdy    (rd_rsp_rdy),
    .o_rd_rsp_data   (rd_rsp_data),
    .o_rd_outstanding(rd_outstanding),
    .o_ram_wren      (ram_wren),
    .o_ram_ren       (ram_ren),
    .o_ram_address   (ram_address),
    .o_ram_wdata     (ram_wdata),
    .i_ram_q         (ram_q)
  );

  // Attached single-port RAM with optional output register.
  logic [W-1:0] ram_mem [1 << AW];
  logic [W-1:0] ram_q0, ram_q1;
  always @(posedge clk) begin
    if (ram_wren) ram_mem[ram_address] <= ram_wdata;
    if (ram_ren) ram_q0 <= ram_mem[ram_address];
    ram_q1 <= ram_q0;
  end
  assign ram_q = (DoReg != 0) ? ram_q1 : ram_q0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: shadow memory updated in grant order, expected responses queued.
  logic [W-1:0]  shadow [1 << AW];
  logic [W-1:0]  exp_q [$];
  int            m_out = 0;
  logic          m_wren = 1'b0, m_ren = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [W-1:0]  m_wdata = '0;
  logic          acc_w, acc_r, pop;
  logic [W-1:0]  exp_d;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_wr_rdy", wr_req_rdy, 0);
      chk("rst_rd_rdy", rd_req_rdy, 0);
      exp_q.delete();
      m_out = 0; m_wren = 0; m_ren = 0; m_addr = '0; m_wdata = '0;
    end else begin
      chk("cmd_wren", ram_wren, m_wren);
      chk("cmd_ren", ram_ren, m_ren);
      chk("cmd_addr", ram_address, m_addr);
      chk("cmd_wdata", ram_wdata, m_wdata);
      chk("outstanding", rd_outstanding, m_out);
      acc_w = wr_req_vld & wr_req_rdy;
      acc_r = rd_req_vld & rd_req_rdy;
      chk("one_grant", acc_w & acc_r, 0);
      if (rd_req_rdy) chk("rd_credit", m_out < Depth, 1);
      if (rd_req_vld && m_out < Depth && !wr_req_vld) chk("rd_uncontended", rd_req_rdy, 1);
      if (wr_req_vld && !(rd_req_vld && m_out < Depth)) chk("wr_uncontended", wr_req_rdy, 1);
      pop = rd_rsp_vld & rd_rsp_rdy;
      if (pop) begin
        chk("rsp_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          exp_d = exp_q.pop_front();
          chk("rsp_data", rd_rsp_data, exp_d);
        end
      end
      m_wren = acc_w;
      m_ren  = acc_r;
      if (acc_w) begin
        m_addr = wr_addr; m_wdata = wr_data; shadow[wr_addr] = wr_data;
      end
      if (acc_r) begin
        m_addr = rd_addr; exp_q.push_back(shadow[rd_addr]);
      end
      m_out = m_out + int'(acc_r) - int'(pop);
    end
  end

  task automatic do_write(input logic [AW-1:0] a, input logic [W-1:0] d, output int n);
    n = 0;
    wr_addr = a; wr_data = d; wr_req_vld = 1'b1;
    do begin @(negedge clk); n++; end while (!wr_req_rdy && n < 50);
    if (!wr_req_rdy) chk("wr_accept_timeout", n, 0);
    @(posedge clk); #1 wr_req_vld = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] a);
    int n = 0;
    rd_addr = a; rd_req_vld = 1'b1;
    do begin @(negedge clk); n++; end while (!rd_req_rdy && n < 50);
    if (!rd_req_rdy) chk("rd_accept_timeout", n, 0);
    @(posedge clk); #1 rd_req_vld = 1'b0;
  endtask

  task automatic rd_single(input logic [AW-1:0] a, output logic [W-1:0] d, output int lat);
    do_read(a);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!rd_rsp_vld && lat < 20);
    d = rd_rsp_data;
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin @(negedge clk); n++; end while ((rd_outstanding != 0 || rd_rsp_vld) && n < 200);
    if (n >= 200) chk("idle_timeout", n, 0);
    @(posedge clk); #1;
  endtask

  logic [W-1:0] prel [16];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int           n, lat, acc;
    logic         got;
    logic [W-1:0] d;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_rsp_vld", rd_rsp_vld, 0);
    chk("reset_rsp_data", rd_rsp_data, 0);
    chk("reset_outstanding", rd_outstanding, 0);
    chk("reset_ram_wren", ram_wren, 0);
    chk("reset_ram_ren", ram_ren, 0);
    chk("reset_ram_addr", ram_address, 0);
    chk("reset_ram_wdata", ram_wdata, 0);
    @(posedge clk); #1;

    // Basic write then read with latency
    do_write(10'h005, 8'hA5, n);
    chk("wr_first_accept", n, 1);
    @(negedge clk);
    chk("wr_pulse_wren", ram_wren, 1);
    chk("wr_pulse_addr", ram_address, 10'h005);
    chk("wr_pulse_data", ram_wdata, 8'hA5);
    @(posedge clk); #1;
    rd_single(10'h005, d, lat);
    chk("basic_rd_data", d, 8'hA5);
    chk("basic_rd_latency", lat, 3 + DoReg);

    // Preload addresses 0..15
    for (int i = 0; i < 16; i++) begin
      prel[i] = W'($urandom);
      do_write(AW'(i), prel[i], n);
    end
    wait_idle();

    // Contention alternates starting with read
    wr_addr = 10'h020; wr_data = W'($urandom); rd_addr = '0;
    wr_req_vld = 1'b1; rd_req_vld = 1'b1;
    for (int i = 0; i < 6; i++) begin
      logic [1:0] g;
      @(negedge clk);
      g = {rd_req_rdy, wr_req_rdy};
      chk("alternate_grant", g, (i % 2 == 0) ? 2'b10 : 2'b01);
      @(posedge clk); #1;
      if (g[0]) begin wr_addr = wr_addr + 1'b1; wr_data = W'($urandom); end
      if (g[1]) rd_addr = rd_addr + 1'b1;
    end
    wr_req_vld = 1'b0; rd_req_vld = 1'b0;
    wait_idle();

    // Backpressure: credits exhausted, writes still flow
    rd_rsp_rdy = 1'b0;
    rd_addr = AW'($urandom_range(0, 15)); rd_req_vld = 1'b1;
    acc = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); got = rd_req_rdy; if (got) acc++;
      @(posedge clk); #1;
      if (got) rd_addr = AW'($urandom_range(0, 15));
    end
    @(negedge clk);
    chk("bp_accepted", acc, 4);
    chk("bp_rd_rdy", rd_req_rdy, 0);
    chk("bp_outstanding", rd_outstanding, 4);
    @(posedge clk); #1;
    do_write(10'h040, 8'h5A, n);
    chk("bp_write_flows", n, 1);
    rd_rsp_rdy = 1'b1;
    for (int i = 0; i < 40 && acc < 6; i++) begin
      @(negedge clk); got = rd_req_rdy; if (got) acc++;
      @(posedge clk); #1;
      if (got) rd_addr = AW'($urandom_range(0, 15));
    end
    rd_req_vld = 1'b0;
    chk("bp_total_accepted", acc, 6);
    wait_idle();
    @(negedge clk);
    chk("bp_outstanding_drained", rd_outstanding, 0);
    @(posedge clk); #1;

    // Full-throughput back-to-back reads
    fork
      begin
        rd_req_vld = 1'b1;
        for (int i = 0; i < 8; i++) begin
          rd_addr = AW'(i);
          @(negedge clk);
          chk("thru_accept", rd_req_rdy, 1);
          @(posedge clk); #1;
        end
        rd_req_vld = 1'b0;
      end
      begin
        int k = 0;
        do begin @(negedge clk); k++; end while (!rd_rsp_vld && k < 40);
        for (int i = 0; i < 8; i++) begin
          if (i > 0) @(negedge clk);
          chk("thru_rsp_vld", rd_rsp_vld, 1);
          chk("thru_rsp_data", rd_rsp_data, prel[i]);
        end
      end
    join
    wait_idle();

    // Reset with two reads in flight
    do_read(10'h003);
    do_read(10'h004);
    rst = 1'b1; wr_req_vld = 1'b1; rd_req_vld = 1'b1; wr_addr = 10'h050;
    @(posedge clk); #1;
    rst = 1'b0; wr_req_vld = 1'b0; rd_req_vld = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rst_flight_no_rsp", rd_rsp_vld, 0);
      chk("rst_flight_outstanding", rd_outstanding, 0);
      if (i == 0) begin
        chk("rst_flight_ren", ram_ren, 0);
        chk("rst_flight_addr", ram_address, 0);
      end
    end
    @(posedge clk); #1;
    rd_single(10'h007, d, lat);
    chk("post_rst_rd_data", d, prel[7]);
    chk("post_rst_rd_latency", lat, 3 + DoReg);

    // Address boundaries
    do_write(10'h3FF, 8'h11, n);
    do_write(10'h000, 8'h22, n);
    rd_single(10'h3FF, d, lat);
    chk("boundary_top", d, 8'h11);
    rd_single(10'h000, d, lat);
    chk("boundary_zero", d, 8'h22);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      wr_req_vld = 1'($urandom);
      wr_addr    = AW'($urandom_range(0, 15));
      wr_data    = W'($urandom);
      rd_req_vld = 1'($urandom);
      rd_addr    = AW'($urandom_range(0, 15));
      rd_rsp_rdy = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    wr_req_vld = 1'b0; rd_req_vld = 1'b0; rd_rsp_rdy = 1'b1;
    wait_idle();
    @(negedge clk);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/spram_rw_ctrl.md
Name: spram_rw_ctrl

Overview:
Access controller sitting on the user side of a single-port RAM (address width RAM_DEEP, optional output register). It accepts independent write and read request streams (valid/ready) and serialises them onto the one RAM port, at most one operation per cycle. It tracks read latency and returns read data in order on a valid/ready response stream. A credit-limited return FIFO absorbs response backpressure.

Parameters:
RAM_DO_REG, 0, 1 = RAM output registered (adds one cycle of read latency); must match the attached RAM.
RAM_WIDTH, 8, data width.
RAM_DEEP, 10, address width; the RAM holds 2**RAM_DEEP words.
RD_FIFO_DEPTH, 4, return FIFO entries (>=1); full read throughput requires >= 4+RAM_DO_REG.

Ports:
clock  in  1  single clock for all logic and the RAM
reset  in  1  synchronous, active-high reset
wr_req_vld  in  1  write request valid
wr_req_rdy  out  1  write request accepted when vld&rdy
wr_addr  in  RAM_DEEP  write address
wr_data  in  RAM_WIDTH  write data
rd_req_vld  in  1  read request valid
rd_req_rdy  out  1  read request accepted when vld&rdy
rd_addr  in  RAM_DEEP  read address
rd_rsp_vld  out  1  read response valid
rd_rsp_rdy  in  1  read response consumed when vld&rdy
rd_rsp_data  out  RAM_WIDTH  read response data
rd_outstanding  out  $clog2(RD_FIFO_DEPTH+1)  accepted reads not yet popped
ram_wren  out  1  to RAM write enable
ram_ren  out  1  to RAM read enable
ram_address  out  RAM_DEEP  to RAM address
ram_wdata  out  RAM_WIDTH  to RAM write data
ram_q  in  RAM_WIDTH  from RAM read data

Behaviour:
- Reset: every output is 0, including ram_address and ram_wdata. The latency pipe and FIFO are cleared, the credit count is 0, and the priority flag is set to "read first". Reads in flight are discarded, and ram_q is never captured for them.
- Read eligibility: rd_ok = (rd_outstanding < RD_FIFO_DEPTH). There is no same-cycle bypass: a pop in cycle c frees a credit from cycle c+1.
- Arbitration, one grant per cycle:
  - Only one side requesting (for reads, requesting means rd_req_vld&rd_ok): that side is granted.
  - Both requesting: the priority flag decides. After each contended grant the flag toggles, so contention alternates R,W,R,W.
  - Uncontended grants do not change the flag.
- wr_req_rdy and rd_req_rdy equal the grant. They may depend combinationally on both valids.
- Command stage is registered. The cycle after a grant:
  - Write grant: ram_wren=1, ram_ren=0, ram_address/ram_wdata = the accepted request.
  - Read grant: ram_ren=1, ram_wren=0, ram_address = rd_addr.
  - No grant: ram_wren=ram_ren=0, and ram_address/ram_wdata hold their last values.
- Latency pipe: a shift register of depth 1+RAM_DO_REG marks which cycles carry valid ram_q. ram_q is written into the FIFO in the cycle the mark emerges: 1+RAM_DO_REG cycles after ram_ren.
- FIFO:
  - Registered, in-order, RD_FIFO_DEPTH entries; the credit scheme guarantees it never overflows.
  - rd_rsp_vld = FIFO not empty; rd_rsp_data = head entry.
  - Accept-to-rd_rsp_vld latency with an empty FIFO is 3+RAM_DO_REG cycles.
- rd_outstanding: +1 on read accept, -1 on rsp pop. A simultaneous accept and pop leaves it unchanged.
- Ordering: operations reach the RAM in grant order, so a read granted after a write to the same address returns the new data. Responses are strictly in accept order.
- Backpressure: with rd_rsp_rdy held low, reads stall once rd_outstanding = RD_FIFO_DEPTH. Writes keep flowing independently.
- Addresses are used as given with no arithmetic; 0 and 2**RAM_DEEP-1 are ordinary.
- Reset mid-operation has the reset behaviour above. Requests presented during reset are not accepted.

Test Plan:
- RAM_DO_REG=0, after reset: write 0x005<-0xA5 then read 0x005 -> ram_wren pulses the cycle after accept; rd_rsp_vld=1 with 0xA5 exactly 3 cycles after read accept (4 cycles with RAM_DO_REG=1).
- wr_req_vld and rd_req_vld held high, distinct data -> grants R,W,R,W starting with read; RAM sees matching alternating ren/wren; responses in order.
- rd_rsp_rdy=0, six reads presented, depth 4 -> exactly 4 accepted, rd_req_rdy=0, rd_outstanding=4, a concurrent write still accepted. Then rd_rsp_rdy=1 -> 4 responses in order; remaining 2 reads accepted; rd_outstanding returns to 0.
- Depth 4, RAM_DO_REG=0, rd_rsp_rdy=1: 8 back-to-back reads of preloaded 0x000..0x007 -> one accept per cycle with no stall; data 0..7 delivered on 8 consecutive cycles.
- Two reads in flight, reset asserted 1 cycle -> no rd_rsp_vld ever for them; rd_outstanding=0; ram_ren=0; a following read works normally.
- Write 0x3FF<-0x11 and 0x000<-0x22, read both -> 0x11 then 0x22 (address boundaries, no wrap corruption).
